axis_eth_fcs_insert: RTL and testbench
======================================

Name: axis_eth_fcs_insert

Overview:
- Transmit-side Ethernet framing stage, 1-byte AXI-Stream.
- Accepts a frame from destination MAC through the last payload byte (no preamble/SFD, no FCS), and emits the same frame zero-padded to the minimum length, followed by the 4-byte CRC-32 FCS.
- Sits directly upstream of the preamble joiner / tx packet FIFO in the loopback path, in the clk25 domain.

Parameters:
- AXIS_BYTES, 1, stream width in bytes; only 1 is supported (elaboration error otherwise).
- MIN_FRAME_BYTES, 60, minimum frame length before FCS (pad target).

Ports:
- clk  in  1  stream clock
- sresetn  in  1  reset, asynchronous assert, active-low
- axis_i_tready  out  1  input ready
- axis_i_tvalid  in  1  input valid
- axis_i_tlast  in  1  last payload byte of frame
- axis_i_tdata  in  8  payload byte
- axis_o_tready  in  1  output ready
- axis_o_tvalid  out  1  output valid
- axis_o_tlast  out  1  asserted on final FCS byte only
- axis_o_tdata  out  8  output byte

Behaviour:
- Reset (async, sresetn=0):
  - axis_o_tvalid=0, axis_o_tlast=0, axis_o_tdata=0, axis_i_tready=0 while asserted.
  - State=PAYLOAD, CRC=0xFFFFFFFF, byte count=0, FCS index=0.
  - Reset mid-frame discards the partial frame; no FCS is emitted for it.
- Output is a single registered stage.
  - The register loads when (!axis_o_tvalid || axis_o_tready).
  - axis_o_tvalid holds until accepted; tdata and tlast are stable while tvalid=1 and tready=0.
  - Latency is 1 cycle input to output; throughput is 1 byte/cycle with no bubbles between payload, pad and FCS.
- axis_i_tready = (state==PAYLOAD) && (!axis_o_tvalid || axis_o_tready). It is combinational from axis_o_tready.
- CRC-32 (IEEE 802.3):
  - Reflected polynomial 0xEDB88320, init 0xFFFFFFFF, LSB-first byte update, final XOR 0xFFFFFFFF.
  - Computed over payload and pad bytes.
  - FCS is transmitted least significant byte first: (~crc)[7:0], [15:8], [23:16], [31:24].
- Byte count is 7 bits, saturating at MIN_FRAME_BYTES, and increments on every payload/pad byte loaded.
- State PAYLOAD:
  - Each accepted input byte is loaded into the output with tlast=0, and CRC and count are updated.
  - On an accepted byte with tlast=1:
    - if count+1 < MIN_FRAME_BYTES, go to PAD;
    - else go to FCS.
- State PAD:
  - Load 0x00 bytes (CRC and count updated) until count reaches MIN_FRAME_BYTES, then go to FCS.
  - No input is accepted.
- State FCS:
  - Load 4 FCS bytes; index 0..3; tlast=1 on index 3.
  - After loading index 3, go to PAYLOAD with CRC reinit, count=0, index=0.
  - The next frame's first byte may be accepted in the cycle after FCS byte 3 is loaded.
- Count saturation: frames longer than MIN_FRAME_BYTES pass unpadded; no maximum-length check.
- A frame whose first accepted byte has tlast=1 (1-byte frame) is legal and is padded.
- Empty input frames are not representable.

Optional Feature:
- Macro AXIS_ETH_FCS_INSERT_PAD_EN.
- Defined: padding as above.
- Undefined: PAD state is not compiled; on input tlast the block always goes to FCS.
  - A 1-byte frame yields 1+4 bytes.
  - The count register is omitted.

Decomposition:
- Package eth_pkg holds:
  - ETH_CRC32_POLY_REFL=32'hEDB88320, ETH_CRC32_INIT=32'hFFFFFFFF, ETH_CRC32_RESIDUE=32'hDEBB20E3;
  - ETH_MIN_FRAME_BYTES=60;
  - a state enum typedef fcs_state_t {PAYLOAD, PAD, FCS};
  - function crc32_update_byte(crc, byte).
- One natural sub-module, eth_crc32: a registered CRC accumulator with init/enable/byte inputs. It is shareable with a future receive-side FCS checker.

Test Plan:
- Pad disabled, input "123456789" (0x31..0x39, tlast on 0x39) -> 13 bytes out: 31..39, then 26 39 F4 CB; tlast only on CB.
- Pad enabled, 1-byte frame 0xAB -> 64 bytes: AB, 59×00, 4 FCS bytes matching the reference model; tlast only on byte 64.
- Pad enabled, 60-byte and 61-byte frames -> no pad bytes, 64 and 65 bytes out.
  - Running a CRC over each full output frame (including FCS) gives residue 0xDEBB20E3.
- Random axis_o_tready (50%) and random input valid gaps across 100 back-to-back frames:
  - output identical to the no-stall run;
  - tdata/tlast stable while stalled;
  - no byte lost or duplicated.
- Assert sresetn=0 mid-payload, after 20 bytes of a frame:
  - tvalid=0 immediately (asynchronous);
  - after release, the next frame 0xAB is output with correct pad and FCS, and no residue of the aborted frame.
- Frame whose tlast arrives while the output is stalled, then a new frame offered immediately:
  - axis_i_tready stays 0 through PAD/FCS;
  - the new frame's first byte is accepted only after FCS byte 3 is loaded.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared Ethernet framing definitions: CRC-32 constants, minimum frame length,
// FCS inserter state encoding and a byte-wide reflected CRC-32 update.
package eth_pkg;

  localparam logic [31:0] ETH_CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] ETH_CRC32_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] ETH_CRC32_RESIDUE   = 32'hDEBB20E3;
  localparam int          ETH_MIN_FRAME_BYTES = 60;

  typedef enum logic [1:0] {PAYLOAD, PAD, FCS} fcs_state_t;

  // One byte through the reflected CRC-32, LSB first.
  function automatic logic [31:0] crc32_update_byte(input logic [31:0] crc,
                                                    input logic [7:0]  b);
    logic [31:0] c;
    c = crc ^ {24'd0, b};
    for (int i = 0; i < 8; i++)
      c = c[0] ? ((c >> 1) ^ ETH_CRC32_POLY_REFL) : (c >> 1);
    return c;
  endfunction

  // A frame with its FCS appended leaves this fixed value in the register.
  function automatic logic crc32_residue_ok(input logic [31:0] crc);
    return crc == ETH_CRC32_RESIDUE;
  endfunction

endpackage

// File: rtl/eth_crc32.sv
// Registered CRC-32 accumulator; init has priority over enable.
// Kept standalone so a receive-side FCS checker can reuse it.
module eth_crc32
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_init,
  input  logic        i_en,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_crc
);

  logic [31:0] r_crc;

  // Accumulate one byte per enabled cycle, restart on init or reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_crc <= ETH_CRC32_INIT;
    else if (i_init) r_crc <= ETH_CRC32_INIT;
    else if (i_en)   r_crc <= crc32_update_byte(r_crc, i_byte);
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/axis_eth_fcs_insert.sv
// Transmit FCS inserter, 1-byte AXI-Stream: payload in, payload (+pad) + FCS out.
// Define AXIS_ETH_FCS_INSERT_PAD_EN to zero-pad short frames to MIN_FRAME_BYTES;
// without it every frame goes straight from its last byte to the FCS.
module axis_eth_fcs_insert
  import eth_pkg::*;
#(
  parameter int AXIS_BYTES      = 1,
  parameter int MIN_FRAME_BYTES = ETH_MIN_FRAME_BYTES
) (
  input  logic       clk,
  input  logic       sresetn,
  output logic       axis_i_tready,
  input  logic       axis_i_tvalid,
  input  logic       axis_i_tlast,
  input  logic [7:0] axis_i_tdata,
  input  logic       axis_o_tready,
  output logic       axis_o_tvalid,
  output logic       axis_o_tlast,
  output logic [7:0] axis_o_tdata
);

  // Only a byte-wide stream exists; the pad counter is 7 bits wide.
  if (AXIS_BYTES != 1 || MIN_FRAME_BYTES < 1 || MIN_FRAME_BYTES > 127) begin : g_param_err
    $error("axis_eth_fcs_insert: AXIS_BYTES must be 1 and MIN_FRAME_BYTES 1..127");
  end

  fcs_state_t  r_state, w_state_nxt;
  logic [1:0]  r_idx, w_idx_nxt;
  logic        r_tvalid, r_tlast;
  logic [7:0]  r_tdata;
  logic        w_load, w_ld_vld, w_ld_last;
  logic [7:0]  w_ld_data, w_fcs_byte;
  logic        w_crc_en, w_crc_init;
  logic [31:0] w_crc, w_fcs;

`ifdef AXIS_ETH_FCS_INSERT_PAD_EN
  localparam logic [6:0] MIN7 = 7'(MIN_FRAME_BYTES);
  logic [6:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  assign w_cnt_inc = (r_cnt >= MIN7) ? r_cnt : r_cnt + 7'd1;
`endif

  // Output register takes a new byte whenever it is empty or being drained.
  assign w_load        = !r_tvalid || axis_o_tready;
  assign axis_i_tready = sresetn && (r_state == PAYLOAD) && w_load;
  assign w_fcs         = ~w_crc;

  // FCS goes out least significant byte first.
  always_comb begin
    case (r_idx)
      2'd0:    w_fcs_byte = w_fcs[7:0];
      2'd1:    w_fcs_byte = w_fcs[15:8];
      2'd2:    w_fcs_byte = w_fcs[23:16];
      default: w_fcs_byte = w_fcs[31:24];
    endcase
  end

  // Next state and the byte to present on the next load.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_ld_vld    = 1'b0;
    w_ld_last   = 1'b0;
    w_ld_data   = 8'h00;
    w_crc_en    = 1'b0;
    w_crc_init  = 1'b0;
`ifdef AXIS_ETH_FCS_INSERT_PAD_EN
    w_cnt_nxt   = r_cnt;
`endif
    case (r_state)
      PAYLOAD: begin
        if (axis_i_tready && axis_i_tvalid) begin
          w_ld_vld  = 1'b1;
          w_ld_data = axis_i_tdata;
          w_crc_en  = 1'b1;
`ifdef AXIS_ETH_FCS_INSERT_PAD_EN
          w_cnt_nxt = w_cnt_inc;
          if (axis_i_tlast) w_state_nxt = (w_cnt_inc < MIN7) ? PAD : FCS;
`else
          if (axis_i_tlast) w_state_nxt = FCS;
`endif
        end
      end
`ifdef AXIS_ETH_FCS_INSERT_PAD_EN
      PAD: begin
        if (w_load) begin
          w_ld_vld  = 1'b1;
          w_crc_en  = 1'b1;
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc >= MIN7) w_state_nxt = FCS;
        end
      end
`endif
      FCS: begin
        if (w_load) begin
          w_ld_vld  = 1'b1;
          w_ld_data = w_fcs_byte;
          w_ld_last = (r_idx == 2'd3);
          w_idx_nxt = r_idx + 2'd1;
          if (r_idx == 2'd3) begin
            w_state_nxt = PAYLOAD;
            w_crc_init  = 1'b1;
`ifdef AXIS_ETH_FCS_INSERT_PAD_EN
            w_cnt_nxt   = 7'd0;
`endif
          end
        end
      end
      default: w_state_nxt = PAYLOAD;
    endcase
  end

  // Control state: frame phase, FCS byte index and pad count.
  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) begin
      r_state <= PAYLOAD;
      r_idx   <= 2'd0;
`ifdef AXIS_ETH_FCS_INSERT_PAD_EN
      r_cnt   <= 7'd0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
`ifdef AXIS_ETH_FCS_INSERT_PAD_EN
      r_cnt   <= w_cnt_nxt;
`endif
    end
  end

  // Single output register stage; holds while stalled.
  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) begin
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_tdata  <= 8'h00;
    end else if (w_load) begin
      r_tvalid <= w_ld_vld;
      r_tlast  <= w_ld_last;
      r_tdata  <= w_ld_data;
    end
  end

  eth_crc32 u_crc (
    .clk    (clk),
    .rst_n  (sresetn),
    .i_init (w_crc_init),
    .i_en   (w_crc_en),
    .i_byte (w_ld_data),
    .o_crc  (w_crc)
  );

  assign axis_o_tvalid = r_tvalid;
  assign axis_o_tlast  = r_tlast;
  assign axis_o_tdata  = r_tdata;

endmodule

// File: tb/tb_axis_eth_fcs_insert.sv
// Scoreboard bench for axis_eth_fcs_insert; follows AXIS_ETH_FCS_INSERT_PAD_EN.
module tb_axis_eth_fcs_insert;

  localparam int MINB = 60;
`ifdef AXIS_ETH_FCS_INSERT_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       sresetn = 1'b0;
  logic       axis_i_tready, axis_i_tvalid = 1'b0, axis_i_tlast = 1'b0;
  logic [7:0] axis_i_tdata = 8'h00;
  logic       axis_o_tready = 1'b1, axis_o_tvalid, axis_o_tlast;
  logic [7:0] axis_o_tdata;

  axis_eth_fcs_insert #(.AXIS_BYTES(1), .MIN_FRAME_BYTES(MINB)) dut (
    .clk(clk), .sresetn(sresetn),
    .axis_i_tready(axis_i_tready), .axis_i_tvalid(axis_i_tvalid),
    .axis_i_tlast(axis_i_tlast), .axis_i_tdata(axis_i_tdata),
    .axis_o_tready(axis_o_tready), .axis_o_tvalid(axis_o_tvalid),
    .axis_o_tlast(axis_o_tlast), .axis_o_tdata(axis_o_tdata)
  );

  always #5 clk = ~clk;

  int   n_checks = 0, n_pass = 0;
  int   rdy_mode = 0;          // 0: always ready, 1: random 50%
  logic [8:0] sb[$];           // expected {tlast, tdata}
  bq_t  mon_frame;
  int   n_done = 0, exp_total = 0, in_cur = 0;
  bit   pend_out = 0, pend_in = 0, pend_in_last = 0, held = 0;
  logic [8:0] held_v = '0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endfunction

  // Bit-serial reflected CRC-32 over a whole message, final-xored.
  function automatic logic [31:0] ref_crc(input bq_t d);
    logic [31:0] c = 32'hFFFFFFFF;
    foreach (d[i])
      for (int b = 0; b < 8; b++)
        c = ((c[0] ^ d[i][b]) == 1'b1) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return ~c;
  endfunction

  function automatic int out_len(input int n);
    return (PAD_EN && n < MINB) ? MINB + 4 : n + 4;
  endfunction

  function automatic void push_expected(input bq_t p);
    bq_t f = p;
    logic [31:0] c;
    if (PAD_EN) while (f.size() < MINB) f.push_back(8'h00);
    c = ref_crc(f);
    foreach (f[i]) sb.push_back({1'b0, f[i]});
    for (int k = 0; k < 4; k++) sb.push_back({k == 3, c[8*k +: 8]});
  endfunction

  function automatic void clear_monitor();
    sb.delete(); mon_frame.delete();
    n_done = 0; exp_total = 0; in_cur = 0;
    pend_out = 0; pend_in = 0; pend_in_last = 0; held = 0;
  endfunction

  // Output backpressure, changed just after each rising edge.
  always begin
    @(posedge clk); #1;
    axis_o_tready = (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: scoreboard, stall stability, residue and input gating.
  always @(negedge clk) begin
    if (sresetn) begin
      if (pend_out) n_done++;
      if (pend_in) begin
        in_cur++;
        if (pend_in_last) begin exp_total += out_len(in_cur); in_cur = 0; end
      end
      // Input may only be taken once everything owed so far is loaded.
      if (axis_i_tready) chk("in_gate", 32'(n_done + int'(axis_o_tvalid)), 32'(exp_total + in_cur));
      if (held) begin
        chk("stall_valid", 32'(axis_o_tvalid), 32'd1);
        chk("stall_hold", 32'({axis_o_tlast, axis_o_tdata}), 32'(held_v));
      end
      held   = axis_o_tvalid && !axis_o_tready;
      held_v = {axis_o_tlast, axis_o_tdata};
      if (axis_o_tvalid && axis_o_tready) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL extra_byte: got %h with nothing expected at %0t", axis_o_tdata, $time);
        end else begin
          chk("out_byte", 32'({axis_o_tlast, axis_o_tdata}), 32'(sb.pop_front()));
        end
        mon_frame.push_back(axis_o_tdata);
        if (axis_o_tlast) begin
          chk("residue", ~ref_crc(mon_frame), 32'hDEBB20E3);
          mon_frame.delete();
        end
      end
      pend_out     = axis_o_tvalid && axis_o_tready;
      pend_in      = axis_i_tvalid && axis_i_tready;
      pend_in_last = axis_i_tlast;
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_byte(input logic [7:0] d, input logic l);
    int t = 0;
    axis_i_tvalid = 1'b1; axis_i_tdata = d; axis_i_tlast = l;
    forever begin
      @(negedge clk);
      if (axis_i_tready) begin @(posedge clk); #1; break; end
      if (++t > 2000) begin chk("in_timeout", 32'd1, 32'd0); break; end
    end
    axis_i_tvalid = 1'b0; axis_i_tlast = 1'b0;
  endtask

  task automatic send_frame(input bq_t p, input bit gaps);
    push_expected(p);
    foreach (p[i]) begin
      if (gaps && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      send_byte(p[i], i == p.size() - 1);
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((sb.size() != 0 || axis_o_tvalid) && t < 5000) begin @(posedge clk); #1; t++; end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  function automatic bq_t rand_frame(input int n);
    bq_t f;
    for (int i = 0; i < n; i++) f.push_back(8'($urandom));
    return f;
  endfunction

  initial begin
    bq_t f;
    // Reset state with downstream ready
    repeat (3) @(negedge clk);
    chk("rst_tvalid", 32'(axis_o_tvalid), 32'd0);
    chk("rst_tlast",  32'(axis_o_tlast),  32'd0);
    chk("rst_tdata",  32'(axis_o_tdata),  32'd0);
    chk("rst_tready", 32'(axis_i_tready), 32'd0);
    @(posedge clk); #1; sresetn = 1'b1;
    @(posedge clk); #1;

    // Standard check vector "123456789"
    f = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    if (!PAD_EN) begin
      foreach (f[i]) sb.push_back({1'b0, f[i]});
      sb.push_back(9'h026); sb.push_back(9'h039); sb.push_back(9'h0F4); sb.push_back(9'h1CB);
      foreach (f[i]) send_byte(f[i], i == 8);
    end else begin
      send_frame(f, 1'b0);
    end
    wait_drain();

    // Length boundaries: 1-byte, exactly minimum, minimum+1
    f = {8'hAB};
    send_frame(f, 1'b0);
    send_frame(rand_frame(MINB), 1'b0);
    send_frame(rand_frame(MINB + 1), 1'b0);
    wait_drain();

    // Back-to-back random frames under random stalls and input gaps
    rdy_mode = 1;
    for (int k = 0; k < 100; k++) send_frame(rand_frame($urandom_range(1, 80)), k[0]);
    wait_drain();
    rdy_mode = 0;
    @(posedge clk); #1;

    // Reset after 20 payload bytes, then a clean 1-byte frame
    for (int i = 0; i < 20; i++) begin
      sb.push_back({1'b0, 8'(i + 8'h40)});
      send_byte(8'(i + 8'h40), 1'b0);
    end
    #1 sresetn = 1'b0;
    #1;
    chk("midrst_tvalid", 32'(axis_o_tvalid), 32'd0);
    chk("midrst_tready", 32'(axis_i_tready), 32'd0);
    clear_monitor();
    repeat (2) @(posedge clk);
    #1 sresetn = 1'b1;
    @(posedge clk); #1;
    f = {8'hAB};
    send_frame(f, 1'b0);
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
